// File: rtl/vector_divide_unit_if.sv
// Handshake and operand/result bus between the issue stage and the vector divider.
interface vector_divide_unit_if;
    localparam int unsigned XLEN = 64;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      bit_mode;
    logic            sign_mode;
    logic            remainder_mode;
    logic [XLEN-1:0] vs2;
    logic [XLEN-1:0] vs1;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] vd;

    modport master (
        output in_valid, bit_mode, sign_mode, remainder_mode, vs2, vs1, out_ready,
        input  in_ready, out_valid, vd
    );

    modport slave (
        input  in_valid, bit_mode, sign_mode, remainder_mode, vs2, vs1, out_ready,
        output in_ready, out_valid, vd
    );
endinterface

// File: rtl/vector_divide_unit.sv
// Iterative SIMD radix-2 restoring divider: SEW 8/16/32/64, signed/unsigned, quotient/remainder.
module vector_divide_unit (
    input  logic                  clock,
    input  logic                  reset,
    vector_divide_unit_if.slave   io
);
    localparam int unsigned XLEN  = 64;
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   vd_q, vd_d;
    logic [XLEN-1:0]   vs2_q, vs2_d;
    logic [XLEN-1:0]   vs1_q, vs1_d;
    logic [1:0]        mode_q, mode_d;
    logic              sign_q, sign_d;
    logic              rem_sel_q, rem_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Per-lane state, each lane zero-extended into a full XLEN word so carries stay in-lane.
    logic [XLEN-1:0]   dvd_q [LANES];
    logic [XLEN-1:0]   dvd_d [LANES];
    logic [XLEN-1:0]   rem_q [LANES];
    logic [XLEN-1:0]   rem_d [LANES];
    logic [XLEN-1:0]   dsr_q [LANES];
    logic [XLEN-1:0]   dsr_d [LANES];
    logic [LANES-1:0]  dvd_neg_q, dvd_neg_d;
    logic [LANES-1:0]  dsr_neg_q, dsr_neg_d;
    logic [LANES-1:0]  zero_q, zero_d;
    logic [LANES-1:0]  ovf_q, ovf_d;

    int unsigned       sew;
    int unsigned       nlanes;
    logic [5:0]        sew_m1;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   msb_only;
    logic [XLEN-1:0]   lane_a, lane_b, lane_q, lane_r;
    logic [XLEN:0]     trial;

    function automatic logic [XLEN-1:0] lane_get(input logic [XLEN-1:0] v, input int unsigned l,
                                                 input int unsigned w, input logic [XLEN-1:0] m);
        return (v >> (l * w)) & m;
    endfunction

    // Element geometry derived from the latched SEW.
    always_comb begin
        sew      = 32'd8 << mode_q;
        nlanes   = LANES >> mode_q;
        sew_m1   = 6'(sew - 32'd1);
        mask     = (sew == XLEN) ? '1 : ((XLEN'(1) << sew) - XLEN'(1));
        msb_only = XLEN'(1) << sew_m1;
    end

    // Next-state, per-lane datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        vd_d        = vd_q;
        vs2_d       = vs2_q;
        vs1_d       = vs1_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        rem_sel_d   = rem_sel_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        dvd_neg_d   = dvd_neg_q;
        dsr_neg_d   = dsr_neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        lane_a      = '0;
        lane_b      = '0;
        lane_q      = '0;
        lane_r      = '0;
        trial       = '0;

        unique case (state_q)
            IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    vs2_d     = io.vs2;
                    vs1_d     = io.vs1;
                    mode_d    = io.bit_mode;
                    sign_d    = io.sign_mode;
                    rem_sel_d = io.remainder_mode;
                    state_d   = PREP;
                end
            end
            PREP: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    dvd_d[l]     = '0;
                    dsr_d[l]     = '0;
                    rem_d[l]     = '0;
                    dvd_neg_d[l] = 1'b0;
                    dsr_neg_d[l] = 1'b0;
                    zero_d[l]    = 1'b0;
                    ovf_d[l]     = 1'b0;
                    if (l < nlanes) begin
                        lane_a       = lane_get(vs2_q, l, sew, mask);
                        lane_b       = lane_get(vs1_q, l, sew, mask);
                        dvd_neg_d[l] = sign_q && lane_a[sew_m1];
                        dsr_neg_d[l] = sign_q && lane_b[sew_m1];
                        dvd_d[l]     = dvd_neg_d[l] ? ((-lane_a) & mask) : lane_a;
                        dsr_d[l]     = dsr_neg_d[l] ? ((-lane_b) & mask) : lane_b;
                        zero_d[l]    = (lane_b == '0);
                        ovf_d[l]     = sign_q && (lane_a == msb_only) && (lane_b == mask);
                    end
                end
                cnt_d   = CNT_W'(sew - 32'd1);
                state_d = ITER;
            end
            ITER: begin
                // One restoring step per lane: shift {rem, dividend}, trial-subtract divisor.
                for (int unsigned l = 0; l < LANES; l++) begin
                    trial    = {rem_q[l], dvd_q[l][sew_m1]};
                    dvd_d[l] = (dvd_q[l] << 1) & mask;
                    if (trial >= {1'b0, dsr_q[l]}) begin
                        rem_d[l]    = trial[XLEN-1:0] - dsr_q[l];
                        dvd_d[l][0] = 1'b1;
                    end else begin
                        rem_d[l]    = trial[XLEN-1:0];
                    end
                end
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIXUP: begin
                vd_d = '0;
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (l < nlanes) begin
                        lane_q = dvd_q[l];
                        lane_r = rem_q[l];
                        if (dvd_neg_q[l] ^ dsr_neg_q[l]) lane_q = (-lane_q) & mask;
                        if (dvd_neg_q[l])                lane_r = (-lane_r) & mask;
                        if (zero_q[l]) begin
                            lane_q = mask;
                            lane_r = lane_get(vs2_q, l, sew, mask);
                        end
                        if (ovf_q[l]) begin
                            lane_q = lane_get(vs2_q, l, sew, mask);
                            lane_r = '0;
                        end
                        vd_d = vd_d | (((rem_sel_q ? lane_r : lane_q) & mask) << (l * sew));
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vd_q        <= '0;
            vs2_q       <= '0;
            vs1_q       <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            rem_sel_q   <= 1'b0;
            cnt_q       <= '0;
            dvd_neg_q   <= '0;
            dsr_neg_q   <= '0;
            zero_q      <= '0;
            ovf_q       <= '0;
            for (int l = 0; l < LANES; l++) begin
                dvd_q[l] <= '0;
                rem_q[l] <= '0;
                dsr_q[l] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            vd_q        <= vd_d;
            vs2_q       <= vs2_d;
            vs1_q       <= vs1_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            rem_sel_q   <= rem_sel_d;
            cnt_q       <= cnt_d;
            dvd_neg_q   <= dvd_neg_d;
            dsr_neg_q   <= dsr_neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.vd        = vd_q;
endmodule

// File: tb/tb_vector_divide_unit.sv
// Randomized and directed self-checking bench for vector_divide_unit against an arithmetic model.
module tb_vector_divide_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vector_divide_unit_if dif ();

    vector_divide_unit dut (
        .clock (clock),
        .reset (reset),
        .io    (dif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Element-wise reference using plain integer division.
    function automatic logic [63:0] ref_div(input logic [1:0] m, input logic s, input logic rs,
                                            input logic [63:0] av, input logic [63:0] bv);
        int unsigned w;
        logic [63:0] mask, res, a, b, q, r;
        longint      sa, sb;
        w    = 32'd8 << m;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        res  = '0;
        for (int unsigned l = 0; l < 64 / w; l++) begin
            a = (av >> (l * w)) & mask;
            b = (bv >> (l * w)) & mask;
            if (b == 0) begin
                q = mask;
                r = a;
            end else if (s) begin
                if (a == (64'd1 << (w - 1)) && b == mask) begin
                    q = a;
                    r = '0;
                end else begin
                    sa = $signed(a << (64 - w)) >>> (64 - w);
                    sb = $signed(b << (64 - w)) >>> (64 - w);
                    q  = 64'(sa / sb);
                    r  = 64'(sa % sb);
                end
            end else begin
                q = a / b;
                r = a % b;
            end
            res = res | (((rs ? r : q) & mask) << (l * w));
        end
        return res;
    endfunction

    task automatic issue(input logic [1:0] m, input logic s, input logic rs,
                         input logic [63:0] a, input logic [63:0] b, output int lat);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!dif.in_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("in_ready_wait", 64'(dif.in_ready), 64'd1);
        dif.bit_mode       = m;
        dif.sign_mode      = s;
        dif.remainder_mode = rs;
        dif.vs2            = a;
        dif.vs1            = b;
        dif.in_valid       = 1'b1;
        @(posedge clock);
        #1;
        dif.in_valid = 1'b0;
        lat = 0;
        while (!dif.out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic drain(input logic [63:0] exp);
        @(negedge clock);
        dif.out_ready = 1'b1;
        @(posedge clock);
        #1;
        dif.out_ready = 1'b0;
        check("out_valid_drop", 64'(dif.out_valid), 64'd0);
        check("in_ready_rise", 64'(dif.in_ready), 64'd1);
        check("vd_hold_idle", dif.vd, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic s, input logic rs,
                          input logic [63:0] a, input logic [63:0] b);
        int lat;
        logic [63:0] exp;
        exp = ref_div(m, s, rs, a, b);
        issue(m, s, rs, a, b, lat);
        check({tag, "_lat"}, 64'(lat), 64'((32'd8 << m) + 32'd2));
        check({tag, "_vd"}, dif.vd, exp);
        drain(exp);
    endtask

    // Random operand lanes biased towards zero, -1, most-negative and small values.
    function automatic logic [63:0] rand_lanes(input logic [1:0] m, input logic is_divisor);
        int unsigned w;
        logic [63:0] mask, v, e;
        w    = 32'd8 << m;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        v    = '0;
        for (int unsigned l = 0; l < 64 / w; l++) begin
            case ($urandom_range(0, 5))
                0:       e = is_divisor ? 64'd0 : (64'd1 << (w - 1));
                1:       e = mask;
                2:       e = 64'($urandom_range(1, 15));
                default: e = {$urandom, $urandom};
            endcase
            v = v | ((e & mask) << (l * w));
        end
        return v;
    endfunction

    initial begin
        int lat;
        int seen;
        logic [63:0] exp;

        dif.in_valid       = 1'b0;
        dif.out_ready      = 1'b0;
        dif.bit_mode       = 2'b00;
        dif.sign_mode      = 1'b0;
        dif.remainder_mode = 1'b0;
        dif.vs2            = '0;
        dif.vs1            = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 64'(dif.in_ready), 64'd1);
        check("rst_out_valid", 64'(dif.out_valid), 64'd0);
        check("rst_vd", dif.vd, 64'd0);

        // Directed cases with hand-derived constants.
        issue(2'b11, 1'b0, 1'b0, 64'd100, 64'd7, lat);
        check("u64q_lat", 64'(lat), 64'd66);
        check("u64q_vd", dif.vd, 64'd14);
        drain(64'd14);
        run_op("u64r", 2'b11, 1'b0, 1'b1, 64'd100, 64'd7);
        check("u64r_const", dif.vd, 64'd2);

        issue(2'b00, 1'b1, 1'b0, 64'h6464_6464_6464_64F9, 64'h0A0A_0A0A_0A0A_0A02, lat);
        check("s8q_lat", 64'(lat), 64'd10);
        check("s8q_vd", dif.vd, 64'h0A0A_0A0A_0A0A_0AFD);
        drain(64'h0A0A_0A0A_0A0A_0AFD);
        run_op("s8r", 2'b00, 1'b1, 1'b1, 64'h6464_6464_6464_64F9, 64'h0A0A_0A0A_0A0A_0A02);
        check("s8r_const", dif.vd, 64'h0000_0000_0000_00FF);

        run_op("z16q", 2'b01, 1'b0, 1'b0, 64'h1234_1234_1234_1234, 64'd0);
        check("z16q_const", dif.vd, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("z16r", 2'b01, 1'b0, 1'b1, 64'h1234_1234_1234_1234, 64'd0);
        check("z16r_const", dif.vd, 64'h1234_1234_1234_1234);

        run_op("ov32q", 2'b10, 1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFE);
        check("ov32q_const", dif.vd, 64'h8000_0000_FFFF_FFFD);
        run_op("ov32r", 2'b10, 1'b1, 1'b1, 64'h8000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFE);
        check("ov32r_const", dif.vd, 64'h0000_0000_0000_0001);
        run_op("u32_allones", 2'b10, 1'b0, 1'b0, 64'h8000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("u32_allones_const", dif.vd, 64'h0000_0000_0000_0001);

        // Randomized sweep over all modes.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            m = 2'($urandom_range(0, 3));
            run_op("rand", m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   rand_lanes(m, 1'b0), rand_lanes(m, 1'b1));
        end

        // Backpressure: DONE holds while a competing request is presented.
        exp = ref_div(2'b01, 1'b1, 1'b0, 64'h8001_7FFF_FF00_0123, 64'h0003_FFF9_0010_0007);
        issue(2'b01, 1'b1, 1'b0, 64'h8001_7FFF_FF00_0123, 64'h0003_FFF9_0010_0007, lat);
        check("bp_lat", 64'(lat), 64'd18);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            dif.in_valid = 1'b1;
            dif.vs2      = {$urandom, $urandom};
            dif.vs1      = 64'd3;
            check("bp_vd_stable", dif.vd, exp);
            check("bp_in_ready_low", 64'(dif.in_ready), 64'd0);
            check("bp_out_valid_high", 64'(dif.out_valid), 64'd1);
        end
        @(negedge clock);
        dif.in_valid = 1'b0;
        drain(exp);
        run_op("bp_next", 2'b00, 1'b0, 1'b0, 64'hFF80_4020_1008_0402, 64'h0303_0303_0303_0303);

        // Reset during ITER aborts the operation.
        @(negedge clock);
        dif.bit_mode       = 2'b11;
        dif.sign_mode      = 1'b0;
        dif.remainder_mode = 1'b0;
        dif.vs2            = 64'd1_000_000;
        dif.vs1            = 64'd3;
        dif.in_valid       = 1'b1;
        @(posedge clock);
        #1;
        dif.in_valid = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_in_ready", 64'(dif.in_ready), 64'd1);
        check("midrst_out_valid", 64'(dif.out_valid), 64'd0);
        check("midrst_vd", dif.vd, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (dif.out_valid) seen++;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        check("midrst_idle_vd", dif.vd, 64'd0);
        run_op("post_rst", 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
